// File: rtl/csa_mult_pkg.sv
// rtl/csa_mult_pkg.sv - shared types and helpers for the sequential carry-save multiplier
package csa_mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Bit counter must index multiplier bits 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/csa_mult_seq_if.sv
// rtl/csa_mult_seq_if.sv - operand/result handshake bundle for csa_mult_seq
interface csa_mult_seq_if #(
  parameter int WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 sgn;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/csa_compress32.sv
// rtl/csa_compress32.sv - one row of W full adders used as a 3:2 compressor
module csa_compress32 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_mult_seq.sv
// rtl/csa_mult_seq.sv - sequential carry-save multiplier, one partial product per clock
module csa_mult_seq
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  csa_mult_seq_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    sum_q;
  logic [PW-1:0]    carry_q;
  logic [PW-1:0]    product_q;
  logic             out_valid_q;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    a_sh;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    cmp_s;
  logic [PW-1:0]    cmp_c;
  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    carry_d;
  logic [PW-1:0]    product_d;
  logic             last_bit;
  logic             neg_row;

  // Signed MSB row carries weight -2^(W-1): add ~row here and its +1 via carry bit 0.
  always_comb begin
    a_ext    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    a_sh     = a_ext << cnt_q;
    last_bit = (cnt_q == LAST);
    neg_row  = last_bit && sgn_q && b_q[cnt_q];
    if (neg_row) begin
      pp = ~a_sh;
    end else if (b_q[cnt_q]) begin
      pp = a_sh;
    end else begin
      pp = '0;
    end
  end

  csa_compress32 #(
    .W (PW)
  ) u_compress (
    .x (sum_q),
    .y (carry_q),
    .z (pp),
    .s (cmp_s),
    .c (cmp_c)
  );

  assign sum_d     = cmp_s;
  assign carry_d   = (cmp_c << 1) | PW'(neg_row);
  assign product_d = sum_q + carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sgn_q   <= bus.sgn;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          product_q   <= product_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
// tb/tb_csa_mult_seq.sv - directed and randomised checks of csa_mult_seq at WIDTH 4 and 8
module tb_csa_mult_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  csa_mult_seq_if #(.WIDTH(4)) bus4 ();
  csa_mult_seq_if #(.WIDTH(8)) bus8 ();

  csa_mult_seq #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  csa_mult_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=4 transaction; operands are scrambled after accept to prove they were latched.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [7:0] exp, input string tag);
    int n;
    int lat;
    n = 0;
    while (!bus4.in_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, bus4.in_ready, 1'b1);
    bus4.a        = a;
    bus4.b        = b;
    bus4.sgn      = s;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    bus4.a        = ~a;
    bus4.b        = ~b;
    bus4.sgn      = ~s;
    check({tag, "_busy"}, {bus4.busy, bus4.in_ready}, 2'b10);
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 5);
    check({tag, "_prod"}, bus4.product, exp);
    if (bus4.out_ready) begin
      tick();
      check({tag, "_ret"}, {bus4.in_ready, bus4.out_valid}, 2'b10);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int stall, input string tag);
    logic [15:0] exp;
    int ai;
    int bi;
    int n;
    int lat;
    ai  = s ? int'($signed(a)) : int'(a);
    bi  = s ? int'($signed(b)) : int'(b);
    exp = 16'(ai * bi);
    n = 0;
    while (!bus8.in_ready && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, bus8.in_ready, 1'b1);
    bus8.a        = a;
    bus8.b        = b;
    bus8.sgn      = s;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid  = 1'b0;
    bus8.a         = 8'($urandom);
    bus8.b         = 8'($urandom);
    bus8.sgn       = ~s;
    bus8.out_ready = (stall == 0);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 9);
    check({tag, "_prod"}, bus8.product, exp);
    for (int k = 0; k < stall; k++) begin
      tick();
      check({tag, "_hold"}, {bus8.out_valid, bus8.product}, {1'b1, exp});
    end
    bus8.out_ready = 1'b1;
    tick();
    check({tag, "_ret"}, {bus8.in_ready, bus8.out_valid}, 2'b10);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.sgn       = 1'b0;
    bus4.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.sgn       = 1'b0;
    bus8.out_ready = 1'b1;
    rst_n          = 1'b0;
    tick();
    tick();
    check("rst4", {bus4.in_ready, bus4.out_valid, bus4.busy, bus4.product}, {3'b100, 8'h00});
    check("rst8", {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.product}, {3'b100, 16'h0000});
    rst_n = 1'b1;
    tick();

    run4(4'd3,  4'd4,  1'b0, 8'd12,  "u3x4");
    run4(4'd10, 4'd7,  1'b0, 8'd70,  "u10x7");
    run4(4'd9,  4'd14, 1'b0, 8'd126, "u9x14");
    run4(4'd6,  4'd6,  1'b0, 8'd36,  "u6x6");
    run4(4'h8,  4'h8,  1'b1, 8'h40,  "sm8xm8");
    run4(4'h8,  4'h7,  1'b1, 8'hC8,  "sm8x7");
    run4(4'h7,  4'hF,  1'b1, 8'hF9,  "s7xm1");
    run4(4'hF,  4'hF,  1'b0, 8'hE1,  "u15x15");
    run4(4'h0,  4'h0,  1'b0, 8'h00,  "u0x0");

    // Backpressure: result held, new operands refused while DONE waits.
    bus4.out_ready = 1'b0;
    run4(4'd3, 4'd5, 1'b0, 8'd15, "bp");
    for (int i = 0; i < 10; i++) begin
      bus4.in_valid = 1'b1;
      bus4.a        = 4'(i);
      bus4.b        = 4'(15 - i);
      bus4.sgn      = i[0];
      tick();
      check("bp_hold", {bus4.in_ready, bus4.out_valid, bus4.product}, {2'b01, 8'd15});
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    tick();
    check("bp_release", {bus4.in_ready, bus4.out_valid, bus4.busy}, 3'b100);
    run4(4'd2, 4'd3, 1'b0, 8'd6, "bp_next");

    // Reset during the second accumulation cycle.
    bus4.a        = 4'd9;
    bus4.b        = 4'd9;
    bus4.sgn      = 1'b0;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    check("mid_busy", bus4.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst", {bus4.in_ready, bus4.out_valid, bus4.busy, bus4.product}, {3'b100, 8'h00});
    tick();
    rst_n = 1'b1;
    tick();
    run4(4'd5, 4'd5, 1'b0, 8'd25, "post_rst");

    run8(8'h00, 8'h00, 1'b0, 0, "w8_0x0");
    run8(8'hFF, 8'hFF, 1'b0, 2, "w8_ffxff");
    check("w8_ffxff_val", bus8.product, 16'hFE01);
    run8(8'h80, 8'h80, 1'b1, 1, "w8_m128sq");
    check("w8_m128sq_val", bus8.product, 16'h4000);
    run8(8'h80, 8'h7F, 1'b1, 0, "w8_m128x127");
    check("w8_m128x127_val", bus8.product, 16'hC080);
    for (int n = 0; n < 1000; n++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "w8_rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
